bcd_display_scanner: RTL and testbench

Time-multiplexing scan controller that shares one BCDTo7Segment decoder between DIGITS display positions. It holds a multi-digit BCD value and presents one digit at a time on `bcd_out`, with a one-hot `digit_en` digit select and an anti-ghosting blank gap between digits. New values are accepted through a valid/ready handshake and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/bcd_display_scanner.sv | 90 +++++++++
 tb/tb_bcd_display_scanner.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexed BCD digit scanner with frame-aligned value commit.
// Define BCD_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_display_scanner #(
    parameter int DIGITS       = 4,
    parameter int DWELL        = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] digits_in,
    input  logic                load_valid,
    output logic                load_ready,
    output logic [3:0]          bcd_out,
    output logic                blank,
    output logic [DIGITS-1:0]   digit_en,
    output logic                frame_start
);
    localparam int MAXC = DWELL > BLANK_CYCLES ? DWELL : BLANK_CYCLES;
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [0:0] S_BLANK = 1'b0;
    localparam logic [0:0] S_SHOW = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic                phase_end, show_end, accept, commit, show, lzb;
    logic [3:0]          nib;

    always_comb begin
        phase_end    = state_q == S_SHOW ? cnt_q == SHOW_LAST : cnt_q == BLANK_LAST;
        show_end     = state_q == S_SHOW && phase_end;
        state_d      = phase_end ? ~state_q : state_q;
        cnt_d        = phase_end ? '0 : cnt_q + 1'b1;
        idx_d        = show_end ? (idx_q == IDX_LAST ? '0 : idx_q + 1'b1) : idx_q;
        accept       = load_valid && !pend_valid_q;
        // pend_valid blocks accept, so commit and accept never coincide
        commit       = show_end && idx_q == IDX_LAST && pend_valid_q;
        pend_d       = accept ? digits_in : pend_q;
        pend_valid_d = accept || (pend_valid_q && !commit);
        disp_d       = commit ? pend_q : disp_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

`ifdef BCD_SCAN_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              upper_zero;
    always_comb begin
        upper_zero = 1'b1;
        lz         = '0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero && disp_q[4*k +: 4] == 4'd0;
            lz[k]      = upper_zero;
        end
    end
    assign lzb = lz[idx_q];
`else
    assign lzb = 1'b0;
`endif

    assign show        = state_q == S_SHOW;
    assign nib         = disp_q[{idx_q, 2'b00} +: 4];
    assign bcd_out     = show ? nib : 4'd0;
    assign blank       = !show || nib > 4'd9 || lzb;
    assign digit_en    = show ? DIGITS'(1) << idx_q : '0;
    assign frame_start = state_q == S_BLANK && idx_q == '0 && cnt_q == '0;
    assign load_ready  = !pend_valid_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed and random checks against a frame-position reference model.
module tb_bcd_display_scanner;
    localparam int DIGITS = 4;
    localparam int DWELL = 4;
    localparam int BLANKC = 2;
    localparam int SLOT = DWELL + BLANKC;
    localparam int FRAME = DIGITS * SLOT;
`ifdef BCD_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready, blank, frame_start;
    logic [3:0]  bcd_out, digit_en;

    int          n_assert = 0;
    int          n_fail = 0;
    int          t;
    logic [15:0] disp_m, pend_m;
    bit          pv_m, acc;

    bcd_display_scanner #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK_CYCLES(BLANKC)) dut (
        .clock(clock), .reset(reset), .digits_in(digits_in), .load_valid(load_valid),
        .load_ready(load_ready), .bcd_out(bcd_out), .blank(blank),
        .digit_en(digit_en), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"}, 32'(digit_en), 0);
        chk({tag, "_bcd"}, 32'(bcd_out), 0);
        chk({tag, "_blank"}, 32'(blank), 1);
        chk({tag, "_fs"}, 32'(frame_start), 1);
        chk({tag, "_ready"}, 32'(load_ready), 1);
    endtask

    task automatic model_reset();
        t = 0;
        disp_m = '0;
        pend_m = '0;
        pv_m = 1'b0;
    endtask

    // Called at a falling edge: check this cycle's outputs, drive inputs, advance the model.
    task automatic step(input logic v, input logic [15:0] d);
        int p, dg, nib;
        bit show, lz;
        #1;
        p    = t % FRAME;
        dg   = p / SLOT;
        show = (p % SLOT) >= BLANKC;
        nib  = int'((disp_m >> (4 * dg)) & 16'hF);
        lz   = LZB && dg > 0 && (disp_m >> (4 * dg)) == 0;
        chk("digit_en", 32'(digit_en), show ? (1 << dg) : 0);
        chk("bcd_out", 32'(bcd_out), show ? nib : 0);
        chk("blank", 32'(blank), (!show || nib > 9 || lz) ? 1 : 0);
        chk("frame_start", 32'(frame_start), p == 0 ? 1 : 0);
        chk("load_ready", 32'(load_ready), pv_m ? 0 : 1);
        load_valid = v;
        digits_in = d;
        acc = v && !pv_m;
        if (acc) begin
            pend_m = d;
            pv_m = 1'b1;
        end else if (p == FRAME - 1 && pv_m) begin
            disp_m = pend_m;
            pv_m = 1'b0;
        end
        t++;
        @(negedge clock);
    endtask

    task automatic load_and_show(input logic [15:0] d);
        int k = 0;
        acc = 1'b0;
        while (!acc && k < 200) begin
            step(1'b1, d);
            k++;
        end
        chk("load_accepted", 32'(acc), 1);
        for (int i = 0; i < 2 * FRAME + 2; i++) step(1'b0, 16'h0);
    endtask

    initial begin
        model_reset();
        #3;
        chk_reset_outputs("por");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0);
        step(1'b1, 16'h1234);
        step(1'b0, 16'h0);
        for (int i = 0; i < 100 && !(acc && digits_in == 16'h5678); i++) step(1'b1, 16'h5678);
        chk("second_load_cycle", 32'(t), 25);
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 16'h0);
        load_and_show(16'h9A00);
        load_and_show(16'h0070);
        load_and_show(16'h0000);
        load_and_show(16'h0105);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) == 0, 16'($urandom));
        for (int i = 0; i < 100 && pv_m; i++) step(1'b0, 16'h0);
        for (int i = 0; i < 200 && !(pv_m && t % FRAME == 2 * SLOT + BLANKC + 1); i++)
            step(1'b1, 16'h4321);
        chk("pending_before_reset", 32'(load_ready), 0);
        chk("digit2_before_reset", 32'(digit_en), 4'b0100);
        load_valid = 1'b1;
        digits_in = 16'h8888;
        #2 reset = 1'b1;
        #1 chk_reset_outputs("mid_reset");
        @(negedge clock);
        load_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < FRAME + 6; i++) step(1'b0, 16'h0);
        load_and_show(16'h0907);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
